// File: rtl/mmu_sel_fork_if.sv
// Upstream request and downstream fork channels of the MMU selector.
// The master modport is the request/consumer side; the slave modport is the selector.
interface mmu_sel_fork_if #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [NUM_PORTS-1:0] i_select;
  logic [DATA_W-1:0]    i_data;
  logic [NUM_PORTS-1:0] o_valid;
  logic [NUM_PORTS-1:0] i_ready;
  logic [DATA_W-1:0]    o_data;
  logic                 o_drop_err;
  logic [CNT_W-1:0]     o_drop_cnt;
  logic                 o_busy;

  modport master (
    output i_valid, i_select, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_drop_err, o_drop_cnt, o_busy
  );

  modport slave (
    input  i_valid, i_select, i_data, i_ready,
    output o_ready, o_valid, o_data, o_drop_err, o_drop_cnt, o_busy
  );
endinterface

// File: rtl/mmu_sel_fork.sv
// Clocked selector/fork: routes one request to a masked subset of consumers and
// holds it until every selected consumer has taken it; illegal masks are dropped.
//
//   state | meaning
//   EMPTY | pending == 0, ready for a new request
//   HOLD  | pending != 0, waiting on the remaining selected consumers
module mmu_sel_fork #(
  parameter int NUM_PORTS   = 5,
  parameter int DATA_W      = 32,
  parameter int ALLOW_MULTI = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmu_sel_fork_if.slave     bus
);

  localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] pendingNext;
  logic [NUM_PORTS-1:0] remain;
  logic [DATA_W-1:0]    dataQ;
  logic                 dropErr;
  logic [CNT_W-1:0]     dropCnt;
  logic                 ready;
  logic                 accept;
  logic                 multiHot;
  logic                 illegal;
  logic                 loadLegal;
  logic                 dropNow;

  // Ready only looks at consumer readies, so a new request can load in the same
  // cycle the last outstanding consumer takes the current one.
  always_comb begin
    remain      = pending & ~bus.i_ready;
    ready       = (remain == '0);
    multiHot    = |(bus.i_select & (bus.i_select - PORT_ONE));
    illegal     = (bus.i_select == '0) || ((ALLOW_MULTI == 0) && multiHot);
    accept      = bus.i_valid && ready;
    loadLegal   = accept && !illegal;
    dropNow     = accept && illegal;
    pendingNext = remain;
    if (loadLegal) begin
      pendingNext = bus.i_select;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      dataQ   <= '0;
      dropErr <= 1'b0;
      dropCnt <= '0;
    end else begin
      pending <= pendingNext;
      dropErr <= dropNow;
      if (loadLegal) begin
        dataQ <= bus.i_data;
      end
      if (dropNow && (dropCnt != '1)) begin
        dropCnt <= dropCnt + CNT_ONE;
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = pending;
  assign bus.o_data     = dataQ;
  assign bus.o_busy     = |pending;
  assign bus.o_drop_err = dropErr;
  assign bus.o_drop_cnt = dropCnt;

endmodule

// File: tb/tb_mmu_sel_fork.sv
// Directed bench for mmu_sel_fork: instance A forks multi-hot masks, instance B
// treats multi-hot masks as illegal.
module tb_mmu_sel_fork;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

  mmu_sel_fork_if #(.NUM_PORTS(5), .DATA_W(32), .CNT_W(8)) busA ();
  mmu_sel_fork_if #(.NUM_PORTS(5), .DATA_W(32), .CNT_W(8)) busB ();

  mmu_sel_fork #(.NUM_PORTS(5), .DATA_W(32), .ALLOW_MULTI(1), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  mmu_sel_fork #(.NUM_PORTS(5), .DATA_W(32), .ALLOW_MULTI(0), .CNT_W(8)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    busA.i_valid = 1'b0; busA.i_select = '0; busA.i_data = '0; busA.i_ready = '0;
    busB.i_valid = 1'b0; busB.i_select = '0; busB.i_data = '0; busB.i_ready = '0;

    // reset state
    #12;
    checkVal("rst_valid", 64'(busA.o_valid), 64'h0);
    checkVal("rst_data", 64'(busA.o_data), 64'h0);
    checkVal("rst_drop_err", 64'(busA.o_drop_err), 64'h0);
    checkVal("rst_drop_cnt", 64'(busA.o_drop_cnt), 64'h0);
    checkVal("rst_busy", 64'(busA.o_busy), 64'h0);
    #5 rst = 1'b0;
    tick();
    checkVal("idle_ready", 64'(busA.o_ready), 64'h1);

    // single one-hot transfer
    busA.i_valid = 1'b1; busA.i_select = 5'b00100; busA.i_data = 32'hDEAD_BEEF; busA.i_ready = 5'b11111;
    #1 checkVal("single_ready_pre", 64'(busA.o_ready), 64'h1);
    tick();
    busA.i_valid = 1'b0;
    checkVal("single_valid", 64'(busA.o_valid), 64'h04);
    checkVal("single_data", 64'(busA.o_data), 64'hDEAD_BEEF);
    checkVal("single_ready", 64'(busA.o_ready), 64'h1);
    checkVal("single_busy", 64'(busA.o_busy), 64'h1);
    tick();
    checkVal("single_clear", 64'(busA.o_valid), 64'h0);
    checkVal("single_ready_post", 64'(busA.o_ready), 64'h1);

    // three-way fork with consumers accepting out of order
    busA.i_ready = 5'b00000;
    busA.i_valid = 1'b1; busA.i_select = 5'b10011; busA.i_data = 32'h1234_5678;
    tick();
    busA.i_valid = 1'b0; busA.i_data = 32'hFFFF_FFFF;
    checkVal("fork_t1_valid", 64'(busA.o_valid), 64'h13);
    busA.i_ready = 5'b00001;
    #1 checkVal("fork_t1_ready", 64'(busA.o_ready), 64'h0);
    tick();
    busA.i_ready = 5'b00000;
    checkVal("fork_t2_valid", 64'(busA.o_valid), 64'h12);
    tick();
    checkVal("fork_t3_valid", 64'(busA.o_valid), 64'h12);
    busA.i_ready = 5'b10001;
    #1 checkVal("fork_t3_ready", 64'(busA.o_ready), 64'h0);
    tick();
    busA.i_ready = 5'b00000;
    checkVal("fork_t4_valid", 64'(busA.o_valid), 64'h02);
    checkVal("fork_t4_data", 64'(busA.o_data), 64'h1234_5678);
    tick();
    checkVal("fork_t5_valid", 64'(busA.o_valid), 64'h02);
    checkVal("fork_t5_ready_lo", 64'(busA.o_ready), 64'h0);
    busA.i_ready = 5'b00010;
    #1 checkVal("fork_t5_ready_hi", 64'(busA.o_ready), 64'h1);
    checkVal("fork_t5_data", 64'(busA.o_data), 64'h1234_5678);
    tick();
    checkVal("fork_done", 64'(busA.o_valid), 64'h0);
    checkVal("fork_busy", 64'(busA.o_busy), 64'h0);

    // zero select is dropped and counted
    busA.i_ready = 5'b11111;
    busA.i_valid = 1'b1; busA.i_select = 5'b00000; busA.i_data = 32'hBAD0_0000;
    tick();
    busA.i_valid = 1'b0;
    checkVal("drop0_err", 64'(busA.o_drop_err), 64'h1);
    checkVal("drop0_cnt", 64'(busA.o_drop_cnt), 64'h1);
    checkVal("drop0_valid", 64'(busA.o_valid), 64'h0);
    checkVal("drop0_data_kept", 64'(busA.o_data), 64'h1234_5678);
    tick();
    checkVal("drop0_pulse_end", 64'(busA.o_drop_err), 64'h0);
    checkVal("drop0_cnt_hold", 64'(busA.o_drop_cnt), 64'h1);

    // 299 further drops: counter saturates at 255
    busA.i_valid = 1'b1;
    for (int i = 0; i < 299; i++) tick();
    busA.i_valid = 1'b0;
    checkVal("sat_cnt", 64'(busA.o_drop_cnt), 64'd255);
    checkVal("sat_err", 64'(busA.o_drop_err), 64'h1);
    tick();
    checkVal("sat_cnt_hold", 64'(busA.o_drop_cnt), 64'd255);
    checkVal("sat_err_end", 64'(busA.o_drop_err), 64'h0);

    // single-hot-only instance: two-hot is illegal, one-hot is routed
    busB.i_ready = 5'b11111;
    busB.i_valid = 1'b1; busB.i_select = 5'b00011; busB.i_data = 32'hCAFE_0001;
    tick();
    busB.i_valid = 1'b0;
    checkVal("b_multi_err", 64'(busB.o_drop_err), 64'h1);
    checkVal("b_multi_cnt", 64'(busB.o_drop_cnt), 64'h1);
    checkVal("b_multi_valid", 64'(busB.o_valid), 64'h0);
    busB.i_valid = 1'b1; busB.i_select = 5'b00010; busB.i_data = 32'hCAFE_0002;
    tick();
    busB.i_valid = 1'b0;
    checkVal("b_onehot_valid", 64'(busB.o_valid), 64'h02);
    checkVal("b_onehot_data", 64'(busB.o_data), 64'hCAFE_0002);
    checkVal("b_onehot_err", 64'(busB.o_drop_err), 64'h0);
    tick();

    // streaming one-hot, always-ready consumers: one transfer per cycle
    busA.i_ready = 5'b11111;
    busA.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      busA.i_select = 5'(1 << i);
      busA.i_data   = 32'h100 + 32'(i);
      #1 checkVal($sformatf("stream%0d_ready", i), 64'(busA.o_ready), 64'h1);
      tick();
      checkVal($sformatf("stream%0d_valid", i), 64'(busA.o_valid), 64'(1 << i));
      checkVal($sformatf("stream%0d_data", i), 64'(busA.o_data), 64'h100 + 64'(i));
    end
    busA.i_valid = 1'b0;
    tick();
    checkVal("stream_end", 64'(busA.o_valid), 64'h0);

    // back-pressure on port 2 with the next request waiting
    busA.i_ready = 5'b00000;
    busA.i_valid = 1'b1; busA.i_select = 5'b00100; busA.i_data = 32'hAAAA_AAAA;
    tick();
    busA.i_select = 5'b00001; busA.i_data = 32'hBBBB_BBBB;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkVal($sformatf("bp%0d_ready", i), 64'(busA.o_ready), 64'h0);
      checkVal($sformatf("bp%0d_valid", i), 64'(busA.o_valid), 64'h04);
      checkVal($sformatf("bp%0d_data", i), 64'(busA.o_data), 64'hAAAA_AAAA);
      tick();
    end
    busA.i_ready = 5'b00100;
    #1 checkVal("bp_release_ready", 64'(busA.o_ready), 64'h1);
    tick();
    busA.i_valid = 1'b0; busA.i_ready = 5'b11111;
    checkVal("bp_load_valid", 64'(busA.o_valid), 64'h01);
    checkVal("bp_load_data", 64'(busA.o_data), 64'hBBBB_BBBB);
    tick();
    checkVal("bp_load_clear", 64'(busA.o_valid), 64'h0);

    // asynchronous reset mid-operation, with a drop pulse in flight on B
    busA.i_ready = 5'b00000;
    busA.i_valid = 1'b1; busA.i_select = 5'b01000; busA.i_data = 32'h5555_5555;
    busB.i_valid = 1'b1; busB.i_select = 5'b00000;
    tick();
    busA.i_valid = 1'b0; busB.i_valid = 1'b0;
    checkVal("mid_valid_pre", 64'(busA.o_valid), 64'h08);
    checkVal("mid_b_err_pre", 64'(busB.o_drop_err), 64'h1);
    #2 rst = 1'b1;
    #1;
    checkVal("mid_valid_rst", 64'(busA.o_valid), 64'h0);
    checkVal("mid_busy_rst", 64'(busA.o_busy), 64'h0);
    checkVal("mid_cnt_rst", 64'(busA.o_drop_cnt), 64'h0);
    checkVal("mid_b_err_rst", 64'(busB.o_drop_err), 64'h0);
    #3 rst = 1'b0;
    tick();
    checkVal("post_rst_valid1", 64'(busA.o_valid), 64'h0);
    tick();
    checkVal("post_rst_valid2", 64'(busA.o_valid), 64'h0);
    busA.i_ready = 5'b11111;
    busA.i_valid = 1'b1; busA.i_select = 5'b00001; busA.i_data = 32'h7777_0001;
    tick();
    busA.i_valid = 1'b0;
    checkVal("post_rst_req_valid", 64'(busA.o_valid), 64'h01);
    checkVal("post_rst_req_data", 64'(busA.o_data), 64'h7777_0001);
    tick();
    checkVal("post_rst_req_clear", 64'(busA.o_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end
endmodule

// File: doc/mmu_sel_fork.md
Name: mmu_sel_fork

Overview:
- Clocked, parametrised successor to the MMU click-based 5-way selector.
- Routes one upstream valid/ready transaction to a subset of NUM_PORTS downstream channels chosen by a per-transaction select mask, and carries a DATA_W payload.
- Supports one-hot routing and optional multi-hot broadcast (fork). A fork completes only when every selected consumer has accepted, in any order and in any cycles.
- Sits between MMU request decode and TLB/PTW/fault-handler consumers. Illegal selects are dropped and counted.

Parameters:
- NUM_PORTS, 5, number of downstream channels (2..16)
- DATA_W, 32, payload width
- ALLOW_MULTI, 1, 1 = multi-hot select forks to all set ports; 0 = multi-hot select is illegal and dropped
- CNT_W, 8, width of saturating drop counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  upstream request valid
- o_ready  out  1  upstream ready
- i_select  in  NUM_PORTS  destination mask, sampled with i_valid&o_ready
- i_data  in  DATA_W  payload
- o_valid  out  NUM_PORTS  per-port valid
- i_ready  in  NUM_PORTS  per-port consumer ready
- o_data  out  DATA_W  shared payload to all ports
- o_drop_err  out  1  one-cycle pulse: an illegal select was accepted and discarded
- o_drop_cnt  out  CNT_W  saturating count of dropped requests
- o_busy  out  1  pending mask non-zero

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- State:
  - pending[NUM_PORTS-1:0]: held entry, outstanding ports.
  - data_q[DATA_W-1:0].
  - States are implicit. EMPTY when pending==0; HOLD otherwise.
- Reset values: pending=0, data_q=0, o_valid=0, o_data=0, o_drop_err=0, o_drop_cnt=0, o_busy=0. o_ready=1 while rst is low and the block is EMPTY.
- Outputs:
  - o_valid = pending; o_data = data_q; o_busy = |pending.
  - o_valid is registered; no combinational path from i_valid.
- Ready:
  - remain = pending & ~i_ready.
  - o_ready = (remain == 0). This is a combinational path from i_ready only; it allows a new accept in the same cycle the last outstanding port accepts.
- Legality:
  - Illegal when i_select==0, or when ALLOW_MULTI==0 and popcount(i_select)>1.
- Accept (i_valid & o_ready):
  - Legal select: next pending = i_select; data_q <= i_data. o_valid rises the next cycle (latency 1).
  - Illegal select: next pending = remain (=0). data_q is unchanged.
  - Illegal select also: o_drop_err=1 for exactly the next cycle, and o_drop_cnt increments, saturating at 2^CNT_W-1.
- No accept: pending <= remain. Each port clears independently on o_valid[k]&i_ready[k]. Ports already cleared are never re-asserted.
- Payload stability: data_q and the set bits of pending stay stable while any bit of pending is set.
- Don't-care inputs: i_ready[k] is ignored while pending[k]==0. i_select and i_data are don't-care when i_valid==0.
- Back-to-back: the last port accepts in cycle t and a new request is accepted in t. The new mask is loaded at t+1 with no bubble; sustained throughput is 1 transaction/cycle for one-hot traffic with always-ready consumers.
- Upstream stability: i_valid held with o_ready=0 requires i_select and i_data to be stable. The block does not check this.
- Reset mid-operation:
  - Pending entries are discarded; no o_valid after reset release until a new accept.
  - Counter clears.
  - An o_drop_err pulse in flight is cancelled.
- Consumer timing: a consumer holding i_ready=1 before o_valid is legal; it takes the transfer in the first o_valid cycle.

Test Plan:
- Reset, then i_valid=1, i_select=5'b00100, i_data=0xDEAD_BEEF, all i_ready=1. Required: o_valid=5'b00100 and o_data=0xDEADBEEF one cycle later; cleared the following cycle; o_ready=1 throughout.
- Fork with ALLOW_MULTI=1, select 5'b10011, i_ready[0]=1 at t+1, i_ready[4]=1 at t+3, i_ready[1]=1 at t+5. Required: o_valid steps 10011 -> 10010 -> 00010 -> 00000; o_ready=0 until the cycle i_ready[1] is seen; o_data is constant.
- Illegal selects. i_select=0: o_drop_err pulses for 1 cycle, o_drop_cnt=1, o_valid stays 0. Repeat 300 times with CNT_W=8: o_drop_cnt saturates at 255. With ALLOW_MULTI=0, select 5'b00011: dropped and counted.
- Streaming: i_valid held 1 with selects 1,2,4,8,16 on successive cycles, all i_ready=1. Required: o_valid one-hot sequence one cycle delayed, no bubbles, o_ready constantly 1.
- Back-pressure: port 2 i_ready=0 for 10 cycles with the next request waiting. Required: o_ready=0, data_q unchanged for 10 cycles; the new request loads the cycle after i_ready[2] rises.
- Reset mid-operation: assert rst asynchronously while o_valid=5'b01000. Required: o_valid=0 immediately; after release it stays 0 with i_valid=0; the next request behaves normally.
